serial_frame_tx: RTL and testbench

- Serial frame transmitter; the send side of the team's serial sync-word link.
- Accepts a parallel payload through a valid/ready handshake.
- Emits one bit per clock, MSB first: 5-bit sync word 10101, then the payload, then an optional even-parity bit.
- The downstream sync-word detector aligns on the sync word; this block produces the stream it consumes.

---
 rtl/serial_frame_tx.sv | 162 ++++++++++++++++
 tb/tb_serial_frame_tx.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_frame_tx.sv
// Serial frame transmitter: sync word, payload MSB first, optional even parity, one bit per clock.
// First sync bit appears the cycle after accept; tx_ready is high only in IDLE, no mid-frame back-pressure.
module serial_frame_tx #(
   parameter int                DATA_W     = 8,
   parameter int                SYNC_W     = 5,
   parameter logic [SYNC_W-1:0] SYNC_PAT   = 5'b10101,
   parameter int                PARITY_EN  = 1,
   parameter int                GAP_CYCLES = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              tx_valid,
   input  logic [DATA_W-1:0] tx_data,
   output logic              tx_ready,
   output logic              dout,
   output logic              dout_en,
   output logic              frame_start,
   output logic              frame_done,
   output logic              busy
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_SYNC   = 3'd1,
      S_DATA   = 3'd2,
      S_PARITY = 3'd3,
      S_GAP    = 3'd4
   } state_t;

   localparam int MAX_W = (SYNC_W > DATA_W) ? SYNC_W : DATA_W;
   localparam int CNT_W = $clog2(MAX_W + 1);
   localparam int GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

   localparam logic [CNT_W-1:0] SYNC_N  = CNT_W'(SYNC_W);
   localparam logic [CNT_W-1:0] DATA_N  = CNT_W'(DATA_W);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [GAP_W-1:0] GAP_N   = GAP_W'(GAP_CYCLES);
   localparam logic [GAP_W-1:0] GAP_ONE = GAP_W'(1);

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [GAP_W-1:0]    gap_q, gap_d;
   logic [SYNC_W-1:0]   sync_q, sync_d;
   logic [DATA_W-1:0]   data_q, data_d;
   logic                par_q, par_d;
   logic                dout_d, dout_en_d, start_d, done_d;
   logic                eof;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         gap_q       <= '0;
         sync_q      <= '0;
         data_q      <= '0;
         par_q       <= 1'b0;
         dout        <= 1'b0;
         dout_en     <= 1'b0;
         frame_start <= 1'b0;
         frame_done  <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         gap_q       <= gap_d;
         sync_q      <= sync_d;
         data_q      <= data_d;
         par_q       <= par_d;
         dout        <= dout_d;
         dout_en     <= dout_en_d;
         frame_start <= start_d;
         frame_done  <= done_d;
      end
   end

   // cnt_q counts bits of the current field already on dout; the state names the field on dout.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      gap_d     = gap_q;
      sync_d    = sync_q;
      data_d    = data_q;
      par_d     = par_q;
      dout_d    = 1'b0;
      dout_en_d = 1'b0;
      start_d   = 1'b0;
      done_d    = 1'b0;
      eof       = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (tx_valid) begin
               state_d   = S_SYNC;
               data_d    = tx_data;
               par_d     = ^tx_data;
               sync_d    = SYNC_PAT << 1;
               cnt_d     = CNT_ONE;
               dout_d    = SYNC_PAT[SYNC_W-1];
               dout_en_d = 1'b1;
               start_d   = 1'b1;
            end
         end
         S_SYNC: begin
            dout_en_d = 1'b1;
            if (cnt_q < SYNC_N) begin
               dout_d = sync_q[SYNC_W-1];
               sync_d = sync_q << 1;
               cnt_d  = cnt_q + 1'b1;
            end else begin
               state_d = S_DATA;
               dout_d  = data_q[DATA_W-1];
               data_d  = data_q << 1;
               cnt_d   = CNT_ONE;
               done_d  = (DATA_W == 1) && (PARITY_EN == 0);
            end
         end
         S_DATA: begin
            if (cnt_q < DATA_N) begin
               dout_en_d = 1'b1;
               dout_d    = data_q[DATA_W-1];
               data_d    = data_q << 1;
               cnt_d     = cnt_q + 1'b1;
               done_d    = (cnt_q == DATA_N - CNT_ONE) && (PARITY_EN == 0);
            end else if (PARITY_EN != 0) begin
               state_d   = S_PARITY;
               dout_en_d = 1'b1;
               dout_d    = par_q;
               done_d    = 1'b1;
            end else begin
               eof = 1'b1;
            end
         end
         S_PARITY: begin
            eof = 1'b1;
         end
         S_GAP: begin
            if (gap_q < GAP_N) begin
               gap_d = gap_q + 1'b1;
            end else begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // The last frame bit is leaving dout at this edge.
      if (eof) begin
         cnt_d = '0;
         if (GAP_CYCLES > 0) begin
            state_d = S_GAP;
            gap_d   = GAP_ONE;
         end else begin
            state_d = S_IDLE;
         end
      end
   end

   assign tx_ready = (state_q == S_IDLE);
   assign busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_serial_frame_tx.sv
// Bench for serial_frame_tx: default instance plus a no-parity, no-gap instance sharing stimulus.
module tb_serial_frame_tx;

   typedef struct {
      logic [63:0] bits;
      int          len;
      int          acc;
   } exp_t;

   logic       clk = 1'b0;
   logic       reset;
   logic       tx_valid;
   logic [7:0] tx_data;
   logic [1:0] rdy_w, dout_w, en_w, fs_w, fd_w, busy_w;

   int          n_cmp = 0;
   int          n_err = 0;
   int          cyc = 0;
   int          acc_last [2] = '{-1000, -1000};
   int          busy_until [2] = '{-1000, -1000};
   int          ncol [2] = '{0, 0};
   int          fs_cnt [2] = '{0, 0};
   logic [63:0] col [2];
   exp_t        q0[$];
   exp_t        q1[$];

   serial_frame_tx u_a (
      .clk(clk), .reset(reset), .tx_valid(tx_valid), .tx_data(tx_data),
      .tx_ready(rdy_w[0]), .dout(dout_w[0]), .dout_en(en_w[0]),
      .frame_start(fs_w[0]), .frame_done(fd_w[0]), .busy(busy_w[0])
   );

   serial_frame_tx #(.PARITY_EN(0), .GAP_CYCLES(0)) u_b (
      .clk(clk), .reset(reset), .tx_valid(tx_valid), .tx_data(tx_data),
      .tx_ready(rdy_w[1]), .dout(dout_w[1]), .dout_en(en_w[1]),
      .frame_start(fs_w[1]), .frame_done(fd_w[1]), .busy(busy_w[1])
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic int pen(input int i);
      return (i == 0) ? 1 : 0;
   endfunction
   function automatic int gapc(input int i);
      return (i == 0) ? 1 : 0;
   endfunction
   function automatic int flen(input int i);
      return 5 + 8 + pen(i);
   endfunction

   // Expected frame as an ordered bit list: sync word, payload MSB first, even parity.
   function automatic exp_t model(input logic [7:0] d, input int i, input int acc);
      exp_t       e;
      logic [4:0] sync;
      sync   = 5'b10101;
      e.bits = '0;
      e.len  = 0;
      for (int k = 4; k >= 0; k--) begin
         e.bits = {e.bits[62:0], sync[k]};
         e.len++;
      end
      for (int k = 7; k >= 0; k--) begin
         e.bits = {e.bits[62:0], d[k]};
         e.len++;
      end
      if (pen(i) != 0) begin
         e.bits = {e.bits[62:0], ($countones(d) % 2) != 0};
         e.len++;
      end
      e.acc = acc;
      return e;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: per-cycle timing checks and frame-level scoreboard comparison.
   always @(negedge clk) begin
      logic exp_en, exp_rdy;
      exp_t e;
      for (int i = 0; i < 2; i++) begin
         if (!reset) begin
            if (i == 0) q0.delete(); else q1.delete();
            ncol[i]       = 0;
            col[i]        = '0;
            acc_last[i]   = -1000;
            busy_until[i] = -1000;
         end else begin
            exp_en  = (cyc >= acc_last[i]) && (cyc <= acc_last[i] + flen(i) - 1);
            exp_rdy = (cyc > busy_until[i]);
            chk($sformatf("dout_en%0d", i), 64'(en_w[i]), 64'(exp_en));
            chk($sformatf("tx_ready%0d", i), 64'(rdy_w[i]), 64'(exp_rdy));
            chk($sformatf("busy%0d", i), 64'(busy_w[i]), 64'(!exp_rdy));
            chk($sformatf("frame_start%0d", i), 64'(fs_w[i]), 64'(cyc == acc_last[i]));
            chk($sformatf("frame_done%0d", i), 64'(fd_w[i]),
                64'(cyc == acc_last[i] + flen(i) - 1));
            if (!en_w[i]) chk($sformatf("idle_dout%0d", i), 64'(dout_w[i]), 64'(0));
            if (fs_w[i]) fs_cnt[i]++;
            if (en_w[i]) begin
               col[i] = {col[i][62:0], dout_w[i]};
               ncol[i]++;
            end
            if (fd_w[i]) begin
               if ((i == 0 && q0.size() == 0) || (i == 1 && q1.size() == 0)) begin
                  n_cmp++;
                  n_err++;
                  $display("FAIL frame_unexpected%0d: got a frame, expected none (cycle %0d)", i, cyc);
               end else begin
                  if (i == 0) e = q0.pop_front(); else e = q1.pop_front();
                  chk($sformatf("frame_len%0d", i), 64'(ncol[i]), 64'(e.len));
                  chk($sformatf("frame_bits%0d", i), col[i], e.bits);
                  chk($sformatf("frame_end_cycle%0d", i), 64'(cyc), 64'(e.acc + e.len - 1));
               end
               ncol[i] = 0;
               col[i]  = '0;
            end
            if (tx_valid && rdy_w[i]) begin
               if (i == 0) q0.push_back(model(tx_data, i, cyc + 1));
               else        q1.push_back(model(tx_data, i, cyc + 1));
               acc_last[i]   = cyc + 1;
               busy_until[i] = cyc + flen(i) + gapc(i);
            end
         end
      end
   end

   task automatic wait_idle();
      int k;
      k = 0;
      @(negedge clk);
      while (rdy_w != 2'b11 && k < 300) begin
         @(negedge clk);
         k++;
      end
      if (rdy_w != 2'b11) begin
         n_cmp++;
         n_err++;
         $display("FAIL idle_timeout: got tx_ready=%b, expected 11 within 300 cycles", rdy_w);
      end
   endtask

   // Single-cycle offer while both instances are idle; payload is scrambled after the accept edge.
   task automatic send(input logic [7:0] d);
      wait_idle();
      @(posedge clk);
      #1;
      tx_valid = 1'b1;
      tx_data  = d;
      @(posedge clk);
      #1;
      tx_valid = 1'b0;
      tx_data  = 8'h00;
   endtask

   task automatic check_reset_state(input string tag);
      for (int i = 0; i < 2; i++) begin
         chk($sformatf("%s_dout%0d", tag, i), 64'(dout_w[i]), 64'(0));
         chk($sformatf("%s_dout_en%0d", tag, i), 64'(en_w[i]), 64'(0));
         chk($sformatf("%s_busy%0d", tag, i), 64'(busy_w[i]), 64'(0));
         chk($sformatf("%s_tx_ready%0d", tag, i), 64'(rdy_w[i]), 64'(1));
         chk($sformatf("%s_start%0d", tag, i), 64'(fs_w[i]), 64'(0));
         chk($sformatf("%s_done%0d", tag, i), 64'(fd_w[i]), 64'(0));
      end
   endtask

   initial begin
      int t_a, f0, f1, k, h;
      reset    = 1'b0;
      tx_valid = 1'b0;
      tx_data  = 8'h00;
      #3;
      check_reset_state("reset");
      #19;
      reset = 1'b1;

      send(8'h07);
      send(8'h55);

      // Held valid: back-to-back frames at minimum spacing.
      wait_idle();
      @(posedge clk);
      #1;
      tx_valid = 1'b1;
      tx_data  = 8'hA5;
      @(posedge clk);
      #1;
      t_a     = cyc;
      tx_data = 8'h3C;
      k = 0;
      while (acc_last[0] == t_a && k < 100) begin
         @(posedge clk);
         #1;
         k++;
      end
      chk("spacing_a", 64'(acc_last[0] - t_a), 64'(16));
      chk("spacing_b", 64'(acc_last[1] - t_a), 64'(14));
      tx_valid = 1'b0;
      tx_data  = 8'h00;

      // Offer while busy must be ignored.
      wait_idle();
      f0 = fs_cnt[0];
      f1 = fs_cnt[1];
      send(8'h96);
      repeat (4) @(posedge clk);
      #1;
      tx_valid = 1'b1;
      tx_data  = 8'hFF;
      @(posedge clk);
      #1;
      tx_valid = 1'b0;
      wait_idle();
      chk("busy_offer_a", 64'(fs_cnt[0] - f0), 64'(1));
      chk("busy_offer_b", 64'(fs_cnt[1] - f1), 64'(1));

      // Asynchronous reset in the middle of the payload.
      send(8'hC3);
      k = 0;
      while (cyc != acc_last[0] + 7 && k < 50) begin
         @(posedge clk);
         #1;
         k++;
      end
      #1;
      reset = 1'b0;
      #1;
      check_reset_state("midreset");
      @(posedge clk);
      #2;
      reset = 1'b1;
      send(8'h5A);

      for (int n = 0; n < 40; n++) begin
         repeat ($urandom_range(0, 3)) @(posedge clk);
         #1;
         tx_valid = 1'b1;
         h = $urandom_range(1, 20);
         for (int j = 0; j < h; j++) begin
            tx_data = 8'($urandom);
            @(posedge clk);
            #1;
         end
         tx_valid = 1'b0;
      end

      wait_idle();
      repeat (3) @(negedge clk);
      chk("pending_a", 64'(q0.size()), 64'(0));
      chk("pending_b", 64'(q1.size()), 64'(0));
      chk("partial_a", 64'(ncol[0]), 64'(0));
      chk("partial_b", 64'(ncol[1]), 64'(0));
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
